// File: rtl/am_ctrl_pkg.sv
// Shared types and default constants for the AM search controller.
// Contents:
//   am_ctrl_state_e  FSM state encoding (StIdle/StIssue/StDrain/StResult)
//   CLASS_STRIDE     default address step between class rows
//   NUM_CLASSES_MAX  default maximum classes per search
//   score_width()    score width helper for a given hypervector length; score_t at the default
package am_ctrl_pkg;

  localparam int unsigned CLASS_STRIDE    = 256;
  localparam int unsigned NUM_CLASSES_MAX = 32;
  localparam int unsigned HV_LENGTH_DEF   = 1024;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StResult
  } am_ctrl_state_e;

  // A popcount of an N-bit vector spans 0..N, so it needs clog2(N)+1 bits.
  function automatic int unsigned score_width(int unsigned hv_len);
    return $clog2(hv_len) + 1;
  endfunction

  typedef logic [score_width(HV_LENGTH_DEF)-1:0] score_t;

endpackage

// File: rtl/am_best_tracker.sv
// Tracks the best and (optionally) second-best score of a search and the index of the best.
// Config macro: AM_SEARCH_MARGIN_EN keeps the second-best register and drives margin_o.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   clr_i             clear all registers (new search)
//   upd_i             present score_i/idx_i as a new candidate
//   score_i, idx_i    candidate score and its class index
//   best_o            best score so far
//   best_idx_o        index of the best score (lowest index wins ties)
//   margin_o          best minus second-best, or 0 when the feature is disabled
module am_best_tracker #(
  parameter int unsigned SCORE_W = 11,
  parameter int unsigned IDX_W   = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               upd_i,
  input  logic [SCORE_W-1:0] score_i,
  input  logic [IDX_W-1:0]   idx_i,
  output logic [SCORE_W-1:0] best_o,
  output logic [IDX_W-1:0]   best_idx_o,
  output logic [SCORE_W-1:0] margin_o
);

  logic [SCORE_W-1:0] best_q, best_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

`ifdef AM_SEARCH_MARGIN_EN
  logic [SCORE_W-1:0] second_q, second_d;

  always_comb begin
    best_d   = best_q;
    idx_d    = idx_q;
    second_d = second_q;
    if (clr_i) begin
      best_d   = '0;
      idx_d    = '0;
      second_d = '0;
    end else if (upd_i) begin
      // Strict compares: an equal score never displaces an earlier class.
      if (score_i > best_q) begin
        second_d = best_q;
        best_d   = score_i;
        idx_d    = idx_i;
      end else if (score_i > second_q) begin
        second_d = score_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      best_q   <= '0;
      idx_q    <= '0;
      second_q <= '0;
    end else begin
      best_q   <= best_d;
      idx_q    <= idx_d;
      second_q <= second_d;
    end
  end

  assign margin_o = best_q - second_q;
`else
  always_comb begin
    best_d = best_q;
    idx_d  = idx_q;
    if (clr_i) begin
      best_d = '0;
      idx_d  = '0;
    end else if (upd_i && (score_i > best_q)) begin
      best_d = score_i;
      idx_d  = idx_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      best_q <= '0;
      idx_q  <= '0;
    end else begin
      best_q <= best_d;
      idx_q  <= idx_d;
    end
  end

  assign margin_o = '0;
`endif

  assign best_o     = best_q;
  assign best_idx_o = idx_q;

endmodule

// File: rtl/am_search_ctrl.sv
// Sequencer/arbiter for the associative-memory search datapath. Issues one AM read per class
// row, collects returned similarity scores, reports the best class through valid/ready, and
// shares the single AM port with host writes (host wins in IDLE and RESULT).
// Config macro: AM_SEARCH_MARGIN_EN enables result_margin_o (best minus second-best).
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   query_valid_i/query_ready_o        query handshake; num_classes_i, am_addr_base_i sampled
//   host_wr_req_i/host_wr_addr_i       host write request; host_wr_gnt_o when performed
//   am_addr_o, am_ren_o, am_wen_o      AM port
//   score_valid_i, score_i             in-order scores from the popcount pipeline
//   result_*                           best class, score, margin with valid/ready
//   busy_o                             FSM not idle
module am_search_ctrl
  import am_ctrl_pkg::*;
#(
  parameter int unsigned HV_LENGTH       = 1024,
  parameter int unsigned AM_ADDR_WIDTH   = 13,
  parameter int unsigned CLASS_STRIDE    = am_ctrl_pkg::CLASS_STRIDE,
  parameter int unsigned NUM_CLASSES_MAX = am_ctrl_pkg::NUM_CLASSES_MAX,
  parameter int unsigned SCORE_W         = $clog2(HV_LENGTH) + 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               query_valid_i,
  output logic                               query_ready_o,
  input  logic [$clog2(NUM_CLASSES_MAX):0]   num_classes_i,
  input  logic [AM_ADDR_WIDTH-1:0]           am_addr_base_i,
  input  logic                               host_wr_req_i,
  input  logic [AM_ADDR_WIDTH-1:0]           host_wr_addr_i,
  output logic                               host_wr_gnt_o,
  output logic [AM_ADDR_WIDTH-1:0]           am_addr_o,
  output logic                               am_ren_o,
  output logic                               am_wen_o,
  input  logic                               score_valid_i,
  input  logic [SCORE_W-1:0]                 score_i,
  output logic                               result_valid_o,
  input  logic                               result_ready_i,
  output logic [$clog2(NUM_CLASSES_MAX)-1:0] result_class_o,
  output logic [SCORE_W-1:0]                 result_score_o,
  output logic [SCORE_W-1:0]                 result_margin_o,
  output logic                               busy_o
);

  localparam int unsigned CntW = $clog2(NUM_CLASSES_MAX) + 1;
  localparam int unsigned IdxW = $clog2(NUM_CLASSES_MAX);
  localparam logic [CntW-1:0] MaxN = CntW'(NUM_CLASSES_MAX);
  localparam logic [AM_ADDR_WIDTH-1:0] Stride = AM_ADDR_WIDTH'(CLASS_STRIDE);

  am_ctrl_state_e           state_q, state_d;
  logic [AM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CntW-1:0]          n_q, n_d;
  logic [CntW-1:0]          issue_q, issue_d;
  logic [CntW-1:0]          ret_q, ret_d;

  logic                     accept;
  logic                     score_take;
  logic                     last_ret;
  logic [CntW-1:0]          n_clamp;
  logic [SCORE_W-1:0]       best;
  logic [SCORE_W-1:0]       margin;
  logic [IdxW-1:0]          best_idx;

  assign n_clamp = (num_classes_i > MaxN) ? MaxN : num_classes_i;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    n_d            = n_q;
    issue_d        = issue_q;
    ret_d          = ret_q;
    accept         = 1'b0;
    query_ready_o  = 1'b0;
    host_wr_gnt_o  = 1'b0;
    am_wen_o       = 1'b0;
    am_ren_o       = 1'b0;
    am_addr_o      = '0;
    result_valid_o = 1'b0;

    // Scores only count while a search is collecting, and never beyond n.
    score_take = score_valid_i && ((state_q == StIssue) || (state_q == StDrain)) && (ret_q < n_q);
    last_ret   = score_take && (ret_q == n_q - 1'b1);
    if (score_take) ret_d = ret_q + 1'b1;

    unique case (state_q)
      StIdle: begin
        host_wr_gnt_o = host_wr_req_i;
        am_wen_o      = host_wr_req_i;
        am_addr_o     = host_wr_addr_i;
        query_ready_o = !host_wr_req_i;
        if (query_valid_i && !host_wr_req_i) begin
          accept  = 1'b1;
          addr_d  = am_addr_base_i;
          n_d     = n_clamp;
          issue_d = '0;
          ret_d   = '0;
          state_d = (n_clamp == '0) ? StResult : StIssue;
        end
      end
      StIssue: begin
        am_ren_o  = 1'b1;
        am_addr_o = addr_q;
        addr_d    = addr_q + Stride;  // wraps modulo the AM depth
        issue_d   = issue_q + 1'b1;
        if (last_ret) begin
          state_d = StResult;
        end else if (issue_q == n_q - 1'b1) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (last_ret) state_d = StResult;
      end
      StResult: begin
        result_valid_o = 1'b1;
        host_wr_gnt_o  = host_wr_req_i;
        am_wen_o       = host_wr_req_i;
        am_addr_o      = host_wr_addr_i;
        if (result_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    result_class_o  = best_idx;
    result_score_o  = best;
    result_margin_o = margin;
    busy_o          = (state_q != StIdle);

    // While in reset every output is forced low apart from the query-ready term.
    if (rst_i) begin
      host_wr_gnt_o   = 1'b0;
      am_wen_o        = 1'b0;
      am_ren_o        = 1'b0;
      am_addr_o       = '0;
      result_valid_o  = 1'b0;
      result_class_o  = '0;
      result_score_o  = '0;
      result_margin_o = '0;
      busy_o          = 1'b0;
      query_ready_o   = !host_wr_req_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      addr_q  <= '0;
      n_q     <= '0;
      issue_q <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      n_q     <= n_d;
      issue_q <= issue_d;
      ret_q   <= ret_d;
    end
  end

  am_best_tracker #(
    .SCORE_W (SCORE_W),
    .IDX_W   (IdxW)
  ) u_best_tracker (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (accept),
    .upd_i      (score_take),
    .score_i    (score_i),
    .idx_i      (ret_q[IdxW-1:0]),
    .best_o     (best),
    .best_idx_o (best_idx),
    .margin_o   (margin)
  );

endmodule

// File: doc/am_search_ctrl.md
Name: am_search_ctrl

Overview:
- Sequencer and arbiter for the associative memory (AM) search datapath.
- Accepts one query per search, issues one AM read per class row at `base + k*CLASS_STRIDE`, and collects the similarity scores returned by the downstream AND/popcount pipeline.
- Reports the best-matching class index and its score through a valid/ready handshake.
- Arbitrates the single AM port between search reads and host class-vector writes.

Parameters:
- HV_LENGTH, 1024, hypervector width; sets score width.
- AM_ADDR_WIDTH, 13, AM address width.
- CLASS_STRIDE, 256, address increment between consecutive class rows.
- NUM_CLASSES_MAX, 32, maximum classes per search.
- SCORE_W, $clog2(HV_LENGTH)+1, score width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- query_valid_i  in  1  encoded HV is stable; start search.
- query_ready_o  out  1  controller accepts a query.
- num_classes_i  in  $clog2(NUM_CLASSES_MAX)+1  classes to scan; sampled at query accept.
- am_addr_base_i  in  AM_ADDR_WIDTH  row of class 0; sampled at query accept.
- host_wr_req_i  in  1  host requests one AM write this cycle.
- host_wr_addr_i  in  AM_ADDR_WIDTH  host write address.
- host_wr_gnt_o  out  1  host write performed this cycle.
- am_addr_o  out  AM_ADDR_WIDTH  AM address.
- am_ren_o  out  1  AM read strobe.
- am_wen_o  out  1  AM write strobe.
- score_valid_i  in  1  similarity score valid; results arrive in issue order, any latency ≥1.
- score_i  in  SCORE_W  similarity score.
- result_valid_o  out  1  result available.
- result_ready_i  in  1  result consumed.
- result_class_o  out  $clog2(NUM_CLASSES_MAX)  best class index.
- result_score_o  out  SCORE_W  best score.
- result_margin_o  out  SCORE_W  best minus second-best score (see Optional Feature).
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Single clock `clk_i`. Reset `rst_i` is synchronous and active-high.
- While `rst_i` is high:
  - State → IDLE.
  - All outputs 0, except `query_ready_o` = !host_wr_req_i.
  - All counters and registers cleared.
- FSM states: IDLE, ISSUE, DRAIN, RESULT.
- IDLE:
  - `host_wr_gnt_o` = `am_wen_o` = host_wr_req_i, and `am_addr_o` = host_wr_addr_i. Combinational; the host has priority.
  - `query_ready_o` = !host_wr_req_i.
  - On query_valid_i && query_ready_o:
    - latch base and `n = min(num_classes_i, NUM_CLASSES_MAX)`;
    - clear best/second/index/issue counter/return counter.
  - If n == 0, go to RESULT with class 0, score 0. Otherwise go to ISSUE.
- ISSUE:
  - One read per cycle: `am_ren_o` = 1, `am_addr_o` = base + k*CLASS_STRIDE for k = 0..n-1, computed modulo 2^AM_ADDR_WIDTH (wraps silently).
  - After issuing k = n-1, go to DRAIN.
  - Host writes are blocked: gnt = 0, and the request is held by the host.
- DRAIN: no AM access; host blocked.
- Scores, accepted in ISSUE and DRAIN:
  - Each score_valid_i pulse is matched to return index r, which increments.
  - If score_i > best: second ← best, best ← score_i, index ← r.
  - Else if score_i > second: second ← score_i.
  - Strict compare, so ties keep the lowest index.
  - When r reaches n (including the score arriving in the last ISSUE cycle), go to RESULT in the next cycle.
  - score_valid_i in IDLE or RESULT is ignored.
  - A score beyond n is ignored.
- RESULT:
  - `result_valid_o` = 1; result outputs are stable until the handshake.
  - On result_ready_i, go to IDLE next cycle; result_valid_o drops.
  - The host may write in RESULT (same rule as IDLE); a new query is not accepted until IDLE.
- Latency: query accept → first `am_ren_o` is the next cycle. Last score → `result_valid_o` is 1 cycle.
- Reset mid-search: abandons the search. Stale scores are flushed by resetting the score pipeline on the same reset.
- `busy_o` = (state != IDLE).

Optional Feature:
- Macro `AM_SEARCH_MARGIN_EN`.
- Defined: the second-best register is kept and `result_margin_o` = best − second. Margin = best when n == 1; 0 when n == 0.
- Undefined: the second-best logic is removed and `result_margin_o` is tied to 0.

Decomposition:
- Package `am_ctrl_pkg`:
  - state enum `am_ctrl_state_e` (IDLE/ISSUE/DRAIN/RESULT);
  - default constants CLASS_STRIDE = 256 and NUM_CLASSES_MAX = 32;
  - a `score_t` width helper.
- One natural sub-module, `am_best_tracker`: best/second/index registers with clear, update and strict-compare logic.

Test Plan:
1. Base = 0, n = 4, scores 10,40,40,7 at latency 2 → reads at 0/256/512/768 on consecutive cycles; result class 1, score 40, margin 0 (with macro).
2. n = 0 query → no `am_ren_o`; result_valid next cycle, class 0, score 0; holds until result_ready_i.
3. host_wr_req_i and query_valid_i together in IDLE → write granted at host_wr_addr_i, query_ready_o = 0; query accepted the following cycle.
4. Host request held during ISSUE/DRAIN → gnt = 0 throughout; gnt = 1 in the first RESULT cycle.
5. Base = 7936, n = 3 → addresses 7936, 0 (wrap), 256; num_classes_i = 40 clamps to 32 reads.
6. `rst_i` asserted during ISSUE with k = 2 → next cycle IDLE, all outputs 0; a fresh query with n = 1, score 5 → class 0, score 5, margin 5 (with macro).
